// File: rtl/pipeline_issue_pkg.sv
// rtl/pipeline_issue_pkg.sv - shared opcodes, NOP encoding, debug FSM states and decode helper
package pipeline_issue_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam logic [7:0] NOP_INST = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2,
        ST_ACK   = 2'd3
    } dbg_state_t;

    typedef struct packed {
        logic       wen;
        logic [1:0] rd;
    } trk_slot_t;

    // Every opcode except NOP writes its rd field.
    function automatic logic inst_writes(input logic [7:0] inst);
        return inst[7:6] != OP_NOP;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// rtl/issue_fifo.sv - per-requester instruction FIFO with combinational head
module issue_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pipeline_issue_arb.sv
// rtl/pipeline_issue_arb.sv - round-robin issue arbiter, write tracker and debug register-read FSM
module pipeline_issue_arb
    import pipeline_issue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_inst,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_inst,
    output logic       req1_ready,
    input  logic       dbg_req,
    input  logic [1:0] dbg_addr,
    output logic       dbg_ack,
    output logic [7:0] dbg_data,
    output logic [7:0] inst_o,
    output logic [1:0] rf_addr_o,
    input  logic [7:0] rf_data_i,
    output logic       busy
);

    logic       w_full0, w_empty0, w_full1, w_empty1;
    logic [7:0] w_head0, w_head1;
    logic       w_push0, w_push1, w_pop0, w_pop1;
    logic       w_arb_en, w_grant0, w_grant1;
    logic [7:0] w_next_inst;
    trk_slot_t  w_next_slot0;
    logic       w_hit;

    dbg_state_t r_state;
    logic       r_rr_last;
    logic [7:0] r_inst;
    trk_slot_t  r_trk0, r_trk1;
    // The oldest slot only needs its valid bit: it retires on the next edge,
    // so its rd never matters for the post-shift drain check.
    logic       r_trk2_wen;
    logic [1:0] r_rf_addr;
    logic [7:0] r_dbg_data;
    logic       r_dbg_ack;

    assign w_push0    = req0_valid & ~w_full0;
    assign w_push1    = req1_valid & ~w_full1;
    assign req0_ready = ~w_full0;
    assign req1_ready = ~w_full1;

    issue_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst),
        .push      (w_push0),
        .push_data (req0_inst),
        .pop       (w_pop0),
        .pop_data  (w_head0),
        .full      (w_full0),
        .empty     (w_empty0)
    );

    issue_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst),
        .push      (w_push1),
        .push_data (req1_inst),
        .pop       (w_pop1),
        .pop_data  (w_head1),
        .full      (w_full1),
        .empty     (w_empty1)
    );

    // Round-robin grant among non-empty FIFOs; NOP when nothing is granted.
    always_comb begin
        w_arb_en = (r_state == ST_IDLE) || (r_state == ST_ACK);
        w_grant1 = w_arb_en && !w_empty1 && (w_empty0 || !r_rr_last);
        w_grant0 = w_arb_en && !w_empty0 && !w_grant1;
        w_pop0   = w_grant0;
        w_pop1   = w_grant1;
        if (w_grant1)      w_next_inst = w_head1;
        else if (w_grant0) w_next_inst = w_head0;
        else               w_next_inst = NOP_INST;
        w_next_slot0.wen = inst_writes(w_next_inst);
        w_next_slot0.rd  = w_next_inst[1:0];
    end

    // Pending write to the captured register in the tracker as it will look after this edge.
    assign w_hit = (w_next_slot0.wen && (w_next_slot0.rd == r_rf_addr)) ||
                   (r_trk0.wen && (r_trk0.rd == r_rf_addr)) ||
                   (r_trk1.wen && (r_trk1.rd == r_rf_addr));

    // Issue register, round-robin pointer and tracker shift (slot 0 mirrors inst_o).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst     <= NOP_INST;
            r_rr_last  <= 1'b1;
            r_trk0     <= '0;
            r_trk1     <= '0;
            r_trk2_wen <= 1'b0;
        end else begin
            r_inst     <= w_next_inst;
            if (w_grant0)      r_rr_last <= 1'b0;
            else if (w_grant1) r_rr_last <= 1'b1;
            r_trk0     <= w_next_slot0;
            r_trk1     <= r_trk0;
            r_trk2_wen <= r_trk1.wen;
        end
    end

    // Debug read FSM: capture address, drain writes to it, sample the register file, pulse ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_rf_addr  <= 2'd0;
            r_dbg_data <= 8'h00;
            r_dbg_ack  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dbg_req) begin
                        r_state   <= ST_DRAIN;
                        r_rf_addr <= dbg_addr;
                    end
                end
                ST_DRAIN: begin
                    if (!w_hit) r_state <= ST_READ;
                end
                ST_READ: begin
                    r_dbg_data <= rf_data_i;
                    r_dbg_ack  <= 1'b1;
                    r_state    <= ST_ACK;
                end
                ST_ACK: begin
                    r_dbg_ack <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign inst_o    = r_inst;
    assign rf_addr_o = r_rf_addr;
    assign dbg_data  = r_dbg_data;
    assign dbg_ack   = r_dbg_ack;
    assign busy      = !w_empty0 || !w_empty1 || r_trk0.wen || r_trk1.wen ||
                       r_trk2_wen || (r_state != ST_IDLE);

endmodule

// File: doc/pipeline_issue_arb.md
# pipeline_issue_arb

Issue controller that sits in front of the 4-register, 3-stage add/sub/and pipeline (ID → EX → WB) and drives its 8-bit `inst` input. It arbitrates round-robin between two instruction requesters, each buffered by its own small FIFO, and inserts NOPs when there is nothing to issue. It also provides a debug register-read service. That service drains in-flight writes to the target register, then samples the pipeline's `dummy_read_rf` / `dummy_rf_data` port.

## Interface
- `DEPTH`, default 4: entries per requester FIFO; must be a power of two and at least 2.
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `req0_valid`  in  1  requester 0 has an instruction.
- `req0_inst`  in  8  instruction fields {op[7:6], rs1[5:4], rs2[3:2], rd[1:0]}.
- `req0_ready`  out  1  FIFO 0 can accept an instruction.
- `req1_valid`, `req1_inst`, `req1_ready`: same as requester 0, for requester 1.
- `dbg_req`  in  1  debug read request; held high until `dbg_ack`.
- `dbg_addr`  in  2  register index to read.
- `dbg_ack`  out  1  one-cycle pulse; `dbg_data` is valid in this cycle.
- `dbg_data`  out  8  captured register value.
- `inst_o`  out  8  connects to the pipeline `inst` input.
- `rf_addr_o`  out  2  connects to the pipeline `dummy_read_rf` input.
- `rf_data_i`  in  8  connects from the pipeline `dummy_rf_data` output (combinational read of the register array).
- `busy`  out  1  any FIFO non-empty, OR any tracker slot valid, OR FSM not in IDLE.

## Operation
- Reset values:
  - `inst_o` = 8'h00 (NOP).
  - `req*_ready` = 1.
  - `dbg_ack` = 0, `dbg_data` = 0, `rf_addr_o` = 0, `busy` = 0.
  - FIFOs empty, tracker cleared, FSM in IDLE, `rr_last` = 1 (requester 0 wins the first tie).
- FIFO push:
  - A push occurs on `valid & ready`.
  - `ready` = not full, regardless of a same-cycle pop.
  - A push while full cannot occur.
- Arbitration:
  - Runs every cycle while the FSM is in IDLE or ACK.
  - Candidates are the non-empty FIFOs.
  - If both are non-empty, the requester not equal to `rr_last` wins.
  - `rr_last` updates only when a grant is made.
  - The winner's head is popped and registered into `inst_o`.
  - With no candidate, `inst_o` ← 8'h00.
- Write tracker:
  - 3 slots of (wen, rd), matching the `inst_o`, ID/EX and EX/WB stages.
  - Shifts every cycle.
  - Slot 0 loads wen = (op ≠ 00) and rd = `inst_o[1:0]` of the instruction being issued.
- Debug FSM states: IDLE, DRAIN, READ, ACK.
  - IDLE → DRAIN when `dbg_req` = 1; `dbg_addr` is captured into `rf_addr_o`.
  - DRAIN: arbitration is paused and `inst_o` ← NOP. DRAIN → READ when no valid tracker slot has rd = the captured address. The check is evaluated on the tracker contents after the cycle's shift; DRAIN lasts at least 1 cycle.
  - READ: `dbg_data` ← `rf_data_i`, `dbg_ack` ← 1; READ → ACK.
  - ACK: `dbg_ack` = 1; ACK → IDLE unconditionally. The requester drops `dbg_req` in this cycle.
- The FIFOs keep accepting pushes in every FSM state.
- Reset mid-operation:
  - All FIFO contents are discarded and the FSM returns to IDLE.
  - An in-progress debug read is abandoned with no `dbg_ack`.

## Timing
- Throughput: one instruction per cycle when not in DRAIN/READ.
- Push-to-issue latency: an instruction pushed at edge E appears on `inst_o` after edge E+1 at the earliest.
- Register-file write point for an instruction placed on `inst_o` after edge T:
  - It writes the register file at edge T+3.
  - The tracker covers exactly that window.
- Debug read latency:
  - With no pending write to the target: `dbg_req` sampled at edge E → DRAIN(E) → READ(E+1) → `dbg_ack` high after E+2.
  - Worst case adds 2 further DRAIN cycles.
- `rf_addr_o` stays stable from DRAIN entry through ACK.
- The pipeline's own synchronous active-high reset is driven from the same source; the tracker is valid only if both resets are applied together.

## Structure
- Shared package `pipeline_issue_pkg`:
  - Opcode constants `OP_NOP`/`OP_ADD`/`OP_SUB`/`OP_AND`.
  - `NOP_INST` = 8'h00.
  - Debug FSM state enum.
  - Function `inst_writes(inst)`.
- Sub-module `issue_fifo`:
  - Parameterised by DEPTH.
  - Instantiated twice.
  - Ports: push/pop/data/full/empty.
- The top level contains the arbiter, tracker and FSM.

## Test plan
- Reset, then idle → `inst_o` = 8'h00, `busy` = 0, both readies = 1.
- Both requesters push continuously (req0 8'h41, req1 8'h86) → `inst_o` alternates 41, 86, 41, … with 41 first.
- Push DEPTH+1 instructions on req0 with no pops possible (hold `dbg_req` to stall in DRAIN on a pending write) → `req0_ready` = 0 after 4 pushes and the FIFO contents are preserved.
- Issue 8'h43 (add r3 = r0 + r0) then immediately raise `dbg_req` with `dbg_addr` = 3 → DRAIN lasts until the write retires, and `dbg_data` equals the new r3 value.
- `dbg_req` with `dbg_addr` = 2 while only r1 writes are in flight → `dbg_ack` occurs 2 cycles after the request.
- Assert `rst` low during DRAIN with both FIFOs non-empty → no `dbg_ack`, FIFOs empty, `inst_o` = 8'h00 immediately.
